// File: rtl/instq_pkg.sv
// -----------------------------------------------------------------------------
// instq_pkg
// Shared constants and field helpers for the instruction prefetch queue and the
// control-unit decoder that consumes its head entry.
//   INSTQ_IW    : default instruction word width
//   INSTQ_OPW   : default opcode field width (upper bits of the word)
//   INSTQ_DEPTH : default number of queue entries (power of two)
//   INSTQ_AW    : address field width (IW - OPW)
// -----------------------------------------------------------------------------
package instq_pkg;

  localparam int INSTQ_IW    = 8;
  localparam int INSTQ_OPW   = 3;
  localparam int INSTQ_DEPTH = 4;
  localparam int INSTQ_AW    = INSTQ_IW - INSTQ_OPW;

  typedef logic [INSTQ_IW-1:0]  instr_t;
  typedef logic [INSTQ_OPW-1:0] opcode_t;
  typedef logic [INSTQ_AW-1:0]  addr_t;

  // Opcode lives in the most significant OPW bits of the word.
  function automatic opcode_t get_opcode(input instr_t word);
    return word[INSTQ_IW-1 -: INSTQ_OPW];
  endfunction

  // Address is everything below the opcode.
  function automatic addr_t get_addr(input instr_t word);
    return word[INSTQ_AW-1:0];
  endfunction

endpackage

// File: rtl/instq_mem.sv
// -----------------------------------------------------------------------------
// instq_mem
// DEPTH x IW register array: one synchronous write port, one asynchronous
// read port. Holds the queue payload; all ordering logic lives in the parent.
//   clk     : clock, rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module instq_mem #(
  parameter int IW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers, so stale words are never observed and no reset fan-out is paid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
// Instruction register with an in-order prefetch queue (show-ahead FIFO)
// between the memory data bus and the control unit. The head entry is
// presented split into opcode and address fields.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   ldir  : push strobe, captures mdat
//   mdat  : instruction word from memory
//   pop   : consumer takes the head entry
//   flush : discard all entries (branch/jump); overrides ldir/pop
//   full  : no free entry
//   valid : head entry present
//   opcd  : head opcode (0 when !valid)
//   adir  : head address (0 when !valid)
//   count : occupied entries
//   ovf   : sticky, push dropped while full
//   udf   : sticky, pop while empty
// Build option: define INSTQ_BYPASS_EN to forward mdat straight to the outputs
// when the queue is empty (zero-latency first fetch).
// -----------------------------------------------------------------------------
module instr_queue
  import instq_pkg::*;
#(
  parameter int IW    = INSTQ_IW,
  parameter int OPW   = INSTQ_OPW,
  parameter int DEPTH = INSTQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ldir,
  input  logic [IW-1:0]              mdat,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       valid,
  output logic [OPW-1:0]             opcd,
  output logic [IW-OPW-1:0]          adir,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          empty, full_w, valid_w;
  logic          byp, pop_mem, pop_byp, push;
  logic [IW-1:0] rdata, head;

  assign empty  = (count_q == '0);
  assign full_w = (count_q == FULL_CNT);

`ifdef INSTQ_BYPASS_EN
  // Empty queue with an incoming word: present mdat directly this cycle.
  assign byp  = empty & ldir & ~flush;
  assign head = empty ? mdat : rdata;
`else
  assign byp  = 1'b0;
  assign head = rdata;
`endif

  assign valid_w = ~empty | byp;
  // A stored entry leaves; a bypassed word is consumed without being written.
  assign pop_mem = pop & ~empty & ~flush;
  assign pop_byp = pop & byp;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push    = ldir & ~flush & (~full_w | pop_mem) & ~pop_byp;

  instq_mem #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (mdat),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_mem) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop_mem})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (ldir & full_w & ~pop_mem) ovf_d = 1'b1;
      if (pop & ~valid_w)           udf_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign full  = full_w;
  assign valid = valid_w;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;
  assign opcd  = valid_w ? head[IW-1 -: OPW]   : '0;
  assign adir  = valid_w ? head[IW-OPW-1:0]    : '0;

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

  localparam int IW    = 8;
  localparam int OPW   = 3;
  localparam int DEPTH = 4;
`ifdef INSTQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst, ldir, pop, flush;
  logic [IW-1:0] mdat;
  logic          full, valid, ovf, udf;
  logic [OPW-1:0]    opcd;
  logic [IW-OPW-1:0] adir;
  logic [2:0]        count;

  instr_queue #(.IW(IW), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .ldir  (ldir),
    .mdat  (mdat),
    .pop   (pop),
    .flush (flush),
    .full  (full),
    .valid (valid),
    .opcd  (opcd),
    .adir  (adir),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: occupancy and sticky flags, plus the scoreboard of words
  // in the order they must leave the queue.
  logic [IW-1:0] exp_q[$];
  int  occ = 0;
  bit  ovf_m = 0, udf_m = 0;
  bit  rst_done = 0;
  // Snapshot of the model as it stands during the current cycle.
  int  cur_occ = 0;
  bit  cur_ovf = 0, cur_udf = 0;
  bit  chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Issue one cycle of stimulus and advance the model to the post-edge state.
  task automatic cyc(input bit r, input bit l, input logic [IW-1:0] d,
                     input bit p, input bit f);
    bit pop_ok, push_ok;
    @(negedge clk);
    cur_occ = occ;
    cur_ovf = ovf_m;
    cur_udf = udf_m;
    chk_en  = rst_done;
    rst = r; ldir = l; mdat = d; pop = p; flush = f;
    if (r) begin
      occ = 0; ovf_m = 0; udf_m = 0;
      rst_done = 1;
    end else if (!f) begin
      pop_ok  = p && (occ > 0 || (BYP && l && occ == 0));
      push_ok = l && (occ < DEPTH || pop_ok);
      if (p && !pop_ok) udf_m = 1;
      if (l && !push_ok) ovf_m = 1;
      if (push_ok) exp_q.push_back(d);
      occ = occ + int'(push_ok) - int'(pop_ok);
    end else begin
      occ = 0;
    end
  endtask

  // Monitor: compares DUT outputs to the model snapshot and drains the
  // scoreboard whenever the consumer takes the presented head.
  always @(negedge clk) begin
    bit exp_valid;
    #2;
    if (chk_en) begin
      exp_valid = (cur_occ > 0) || (BYP && ldir && !flush && cur_occ == 0);
      check("count", 32'(count), 32'(cur_occ));
      check("full",  32'(full),  32'(cur_occ == DEPTH));
      check("valid", 32'(valid), 32'(exp_valid));
      check("ovf",   32'(ovf),   32'(cur_ovf));
      check("udf",   32'(udf),   32'(cur_udf));
      if (exp_valid && exp_q.size() > 0) begin
        logic [IW-1:0] w;
        w = exp_q[0];
        check("opcd", 32'(opcd), 32'(w[IW-1:IW-OPW]));
        check("adir", 32'(adir), 32'(w[IW-OPW-1:0]));
      end else if (!exp_valid) begin
        check("opcd_idle", 32'(opcd), 32'd0);
        check("adir_idle", 32'(adir), 32'd0);
      end
      if (rst || flush) exp_q.delete();
      else if (pop && exp_valid && exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (rst) begin
      exp_q.delete();
    end
  end

  initial begin
    rst = 1'b0; ldir = 1'b0; pop = 1'b0; flush = 1'b0; mdat = '0;

    // Reset with a push strobe asserted: nothing may be captured.
    cyc(1, 1, 8'hFF, 0, 0);
    cyc(1, 1, 8'hFF, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);

    // Field split, then drain.
    cyc(0, 1, 8'b101_01100, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);

    // Fill, push+pop at full, then overflow and drain in order.
    cyc(0, 1, 8'h11, 0, 0);
    cyc(0, 1, 8'h22, 0, 0);
    cyc(0, 1, 8'h33, 0, 0);
    cyc(0, 1, 8'h44, 0, 0);
    cyc(0, 1, 8'h66, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 1, 8'h55, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1, 0);
    cyc(1, 0, 8'h00, 0, 0);

    // Flush overrides a simultaneous push and pop.
    cyc(0, 1, 8'hA1, 0, 0);
    cyc(0, 1, 8'hB2, 0, 0);
    cyc(0, 1, 8'hC3, 0, 0);
    cyc(0, 1, 8'hD4, 1, 1);
    cyc(0, 0, 8'h00, 0, 0);

    // Pointer wrap-around with paired push/pop.
    cyc(0, 1, 8'h01, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'(8'h20 + i), 1, 0);
    cyc(0, 0, 8'h00, 1, 0);

    // Push and pop into an empty queue (bypass or underflow), then underflow.
    cyc(1, 0, 8'h00, 0, 0);
    cyc(0, 1, 8'h9A, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);

    // Randomized traffic with occasional flush and reset.
    cyc(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 60,
          8'($urandom),
          $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 4);
    end
    cyc(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
